// File: rtl/reset_sequencer.sv
// Per-domain reset generator: async assert, synchronised and stretched deassert,
// staggered release, masked software reset and last-cause capture.
module reset_sequencer #(
  parameter int unsigned N_RST          = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STAGGER_CYCLES = 4
) (
  input  logic             sys_clk,
  input  logic             ext_reset_n,
  input  logic             sw_rst_req,
  input  logic [N_RST-1:0] sw_rst_mask,
  output logic [N_RST-1:0] rst_out_n,
  output logic             rst_done,
  output logic [1:0]       rst_cause
);

  localparam int unsigned CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (N_RST > 1) ? $clog2(N_RST) : 1;

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [N_RST-1:0] rst_q,   rst_d;
  logic             done_q,  done_d;
  logic [1:0]       cause_q, cause_d;

  // Deassertion synchroniser; cleared asynchronously by the board reset
  always_ff @(posedge sys_clk or negedge ext_reset_n) begin
    if (!ext_reset_n) sync_q <= '0;
    else              sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // State and registered outputs
  always_ff @(posedge sys_clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_EXT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  // Next-state: stretch in HOLD, one domain per stagger slot in RELEASE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    cause_d = cause_q;

    case (state_q)
      HOLD: begin
        if (sync_out) begin
          if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
            cnt_d    = '0;
            rst_d[0] = 1'b1;
            if (N_RST == 1) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      RELEASE: begin
        if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
          cnt_d = '0;
          rst_d = rst_q | (N_RST'(1) << idx_q);
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N_RST - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        // Unmasked domains keep running; the walk still visits every index
        if (sw_rst_req && (sw_rst_mask != '0)) begin
          state_d = HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = rst_q & ~sw_rst_mask;
          done_d  = 1'b0;
          cause_d = CAUSE_SW;
        end
      end

      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign rst_out_n = rst_q;
  assign rst_done  = done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timing-formula reference model queues
// expected output changes, a monitor pops them whenever a DUT output changes.
module tb_reset_sequencer;

  localparam int N_M  = 4;
  localparam int SY_M = 2;
  localparam int ST_M = 16;
  localparam int SG_M = 4;
  localparam int N_S  = 1;
  localparam int SY_S = 3;
  localparam int ST_S = 1;
  localparam int SG_S = 1;

  localparam int     K_EXT = 0;
  localparam int     K_SW  = 1;
  localparam longint NEVER = 64'sd1099511627776;

  typedef struct {
    longint     cyc;
    logic [6:0] val;
  } ev_t;

  logic       sys_clk = 1'b0;
  logic       ext_reset_n;
  logic       sw_rst_req;
  logic [3:0] sw_rst_mask;
  logic [3:0] rst_m;
  logic       done_m;
  logic [1:0] cause_m;
  logic [0:0] rst_s;
  logic       done_s;
  logic [1:0] cause_s;

  ev_t q0[$];
  ev_t q1[$];

  longint     cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         kind[2];
  longint     base[2];
  logic [3:0] msk[2];
  logic [6:0] mdl_last[2];
  bit         mdl_init[2];
  logic [6:0] mon_prev[2];
  bit         mon_init[2];

  always #5 sys_clk = ~sys_clk;

  reset_sequencer #(
    .N_RST(N_M), .SYNC_STAGES(SY_M), .STRETCH_CYCLES(ST_M), .STAGGER_CYCLES(SG_M)
  ) dut_main (
    .sys_clk(sys_clk), .ext_reset_n(ext_reset_n), .sw_rst_req(sw_rst_req),
    .sw_rst_mask(sw_rst_mask), .rst_out_n(rst_m), .rst_done(done_m), .rst_cause(cause_m)
  );

  reset_sequencer #(
    .N_RST(N_S), .SYNC_STAGES(SY_S), .STRETCH_CYCLES(ST_S), .STAGGER_CYCLES(SG_S)
  ) dut_small (
    .sys_clk(sys_clk), .ext_reset_n(ext_reset_n), .sw_rst_req(sw_rst_req),
    .sw_rst_mask(sw_rst_mask[0:0]), .rst_out_n(rst_s), .rst_done(done_s), .rst_cause(cause_s)
  );

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Expected {rst_out_n, rst_done, rst_cause} at cycle c from the release-time formulas
  function automatic logic [6:0] model(input int d, input longint c);
    int         n, sy, st, sg;
    longint     t;
    logic [3:0] r;
    logic       dn;
    logic [1:0] cs;
    n  = (d == 0) ? N_M  : N_S;
    sy = (d == 0) ? SY_M : SY_S;
    st = (d == 0) ? ST_M : ST_S;
    sg = (d == 0) ? SG_M : SG_S;
    t  = c - base[d];
    r  = '0;
    if (kind[d] == K_EXT) begin
      for (int k = 0; k < n; k++) r[k] = (t >= longint'(sy + st + k * sg));
      dn = (t >= longint'(sy + st + (n - 1) * sg));
      cs = 2'b01;
    end else begin
      for (int k = 0; k < n; k++) r[k] = !msk[d][k] || (t >= longint'(st + k * sg));
      dn = (t >= longint'(st + (n - 1) * sg));
      cs = 2'b10;
    end
    return {r, dn, cs};
  endfunction

  function automatic int qsz(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qpop(input int d);
    ev_t e;
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    return e;
  endfunction

  function automatic longint qfront_cyc(input int d);
    return (d == 0) ? q0[0].cyc : q1[0].cyc;
  endfunction

  // Reference model: push an expected event whenever the modelled outputs change
  always @(posedge sys_clk) begin : mdl
    logic [6:0] v;
    ev_t        e;
    #4;
    for (int d = 0; d < 2; d++) begin
      v = model(d, cyc);
      if (!mdl_init[d] || v != mdl_last[d]) begin
        e.cyc = cyc;
        e.val = v;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        mdl_last[d] = v;
        mdl_init[d] = 1'b1;
      end
    end
  end

  task automatic check_dut(input int d, input logic [6:0] cur);
    ev_t e;
    while (qsz(d) > 0 && qfront_cyc(d) < cyc) begin
      e = qpop(d);
      vectors++;
      miscompares++;
      $display("FAIL missing_change dut%0d cyc=%0d got=none exp=%b exp_cyc=%0d", d, cyc, e.val, e.cyc);
    end
    if (!mon_init[d] || cur != mon_prev[d]) begin
      vectors++;
      if (qsz(d) == 0) begin
        miscompares++;
        $display("FAIL unexpected_change dut%0d cyc=%0d got=%b exp=no_change", d, cyc, cur);
      end else begin
        e = qpop(d);
        if (e.cyc != cyc || e.val != cur) begin
          miscompares++;
          $display("FAIL output_change dut%0d cyc=%0d got=%b exp=%b exp_cyc=%0d", d, cyc, cur, e.val, e.cyc);
        end
      end
      mon_prev[d] = cur;
      mon_init[d] = 1'b1;
    end
  endtask

  // Monitor: sample away from the active edge and pop on every output change
  always @(negedge sys_clk) begin
    check_dut(0, {rst_m, done_m, cause_m});
    check_dut(1, {3'b000, rst_s, done_s, cause_s});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic ext_low();
    ext_reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      kind[d] = K_EXT;
      base[d] = NEVER;
    end
  endtask

  task automatic ext_high();
    ext_reset_n = 1'b1;
    for (int d = 0; d < 2; d++) base[d] = cyc;
  endtask

  // One-cycle request; acceptance decided from the model's RUN status before the edge
  task automatic sw_pulse(input logic [3:0] m);
    bit         acc[2];
    logic [6:0] cur;
    sw_rst_mask = m;
    sw_rst_req  = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cur    = model(d, cyc);
      acc[d] = cur[2] && ((d == 0) ? (m != 4'b0000) : m[0]);
    end
    tick(1);
    sw_rst_req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) begin
        kind[d] = K_SW;
        base[d] = cyc;
        msk[d]  = m;
      end
    end
  endtask

  initial begin
    ext_reset_n = 1'b1;
    sw_rst_req  = 1'b0;
    sw_rst_mask = 4'b0000;
    for (int d = 0; d < 2; d++) begin
      kind[d] = K_EXT;
      base[d] = NEVER;
      msk[d]  = 4'b0000;
    end
    #1 ext_low();
    tick(5);
    ext_high();

    // Request while the main block is still releasing
    tick(20);
    sw_pulse(4'b1111);
    tick(15);
    sw_pulse(4'b0000);
    tick(5);
    sw_pulse(4'b1100);
    tick(35);

    for (int i = 0; i < 8; i++) begin
      sw_pulse(4'($urandom));
      tick(int'($urandom_range(1, 40)));
    end
    tick(40);

    // Assert between clock edges while running
    #2 ext_low();
    tick(3);
    ext_high();
    tick(35);

    // Software reset aborted by the board reset
    sw_pulse(4'b1100);
    tick(10);
    ext_low();
    tick(2);
    ext_high();
    tick(35);

    // Sub-cycle glitch
    #1 ext_low();
    #1 ext_high();
    tick(35);

    for (int i = 0; i < 3; i++) begin
      sw_pulse(4'($urandom_range(1, 15)));
      tick(int'($urandom_range(1, 30)));
      ext_low();
      tick(int'($urandom_range(1, 3)));
      ext_high();
      tick(35);
    end

    tick(5);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (qsz(d) != 0) begin
        miscompares++;
        $display("FAIL pending_events dut%0d got=%0d exp=0", d, qsz(d));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
